// File: rtl/pentarv_pkg.sv
// Shared constants and types for the register-file write-back path.
package pentarv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_HEAD,
    SEL_MEM,
    SEL_ALU
  } wb_sel_e;

  function automatic wb_entry_t mk_entry(input logic [REG_AW-1:0] rd,
                                         input logic [XLEN-1:0]   data);
    wb_entry_t e;
    e.rd   = rd;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/regfile_wb_ctrl_wb_queue.sv
// Deferred-write FIFO: two pushes (push0 lands first) and one pop per cycle.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module wb_queue
  import pentarv_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push0,
  input  wb_entry_t       push0_data,
  input  logic            push1,
  input  wb_entry_t       push1_data,
  input  logic            pop,
  output logic [CW-1:0]   count,
  output wb_entry_t       head
);

  wb_entry_t         mem_q [DEPTH];
  wb_entry_t         mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (push0) begin
      mem_d[wr_ptr_d] = push0_data;
      wr_ptr_d        = ptr_inc(wr_ptr_d);
    end
    if (push1) begin
      mem_d[wr_ptr_d] = push1_data;
      wr_ptr_d        = ptr_inc(wr_ptr_d);
    end
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(push0) + CW'(push1) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    count = count_q;
    head  = mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: merges ALU/load results onto the single register-file
// write port, defers collisions, and tracks RAW hazards. Optional REGFILE_BYPASS_EN.
module regfile_wb_ctrl #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_vld,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              alu_vld,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              mem_vld,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  output logic              src_ready,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic              stall,
  output logic              we,
  output logic [REG_AW-1:0] rd,
  output logic [XLEN-1:0]   wd,
  output logic              fwd1_vld,
  output logic              fwd2_vld,
  output logic [XLEN-1:0]   fwd1_data,
  output logic [XLEN-1:0]   fwd2_data
);

  import pentarv_pkg::wb_entry_t;
  import pentarv_pkg::wb_sel_e;
  import pentarv_pkg::SEL_NONE;
  import pentarv_pkg::SEL_HEAD;
  import pentarv_pkg::SEL_MEM;
  import pentarv_pkg::SEL_ALU;
  import pentarv_pkg::mk_entry;

  localparam int unsigned CW   = $clog2(DEPTH + 1);
  localparam int unsigned NREG = 1 << REG_AW;

  logic [CW-1:0]     q_count;
  wb_entry_t         q_head;
  logic              head_vld, mem_ok, alu_ok;
  logic              push0, push1, pop;
  wb_sel_e           sel;
  wb_entry_t         win;

  logic              we_q, we_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [XLEN-1:0]   wd_q, wd_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              hit1, hit2;

  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push0      (push0),
    .push0_data (mk_entry(mem_rd, mem_data)),
    .push1      (push1),
    .push1_data (mk_entry(alu_rd, alu_data)),
    .pop        (pop),
    .count      (q_count),
    .head       (q_head)
  );

  // Results arriving while not ready, or aimed at x0, never enter the path.
  always_comb begin
    head_vld  = (q_count != '0);
    src_ready = ((CW'(DEPTH) - q_count) >= CW'(2));
    mem_ok    = mem_vld & src_ready & (mem_rd != '0);
    alu_ok    = alu_vld & src_ready & (alu_rd != '0);

    if (head_vld)    sel = SEL_HEAD;
    else if (mem_ok) sel = SEL_MEM;
    else if (alu_ok) sel = SEL_ALU;
    else             sel = SEL_NONE;

    pop   = (sel == SEL_HEAD);
    push0 = mem_ok & (sel != SEL_MEM);
    push1 = alu_ok & (sel != SEL_ALU);

    case (sel)
      SEL_HEAD: win = q_head;
      SEL_MEM:  win = mk_entry(mem_rd, mem_data);
      SEL_ALU:  win = mk_entry(alu_rd, alu_data);
      default:  win = mk_entry(rd_q, wd_q);
    endcase

    we_d = (sel != SEL_NONE);
    rd_d = win.rd;
    wd_d = win.data;
  end

  // The issue set is applied after the write clear so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (we_d) busy_d[rd_d] = 1'b0;
    if (issue_vld && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q   <= 1'b0;
      rd_q   <= '0;
      wd_q   <= '0;
      busy_q <= '0;
    end else begin
      we_q   <= we_d;
      rd_q   <= rd_d;
      wd_q   <= wd_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    we = we_q;
    rd = rd_q;
    wd = wd_q;
`ifdef REGFILE_BYPASS_EN
    hit1      = we_q & (rd_q != '0) & (rd_q == rs1);
    hit2      = we_q & (rd_q != '0) & (rd_q == rs2);
    fwd1_vld  = hit1;
    fwd2_vld  = hit2;
    fwd1_data = wd_q;
    fwd2_data = wd_q;
`else
    hit1      = 1'b0;
    hit2      = 1'b0;
    fwd1_vld  = 1'b0;
    fwd2_vld  = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
`endif
    stall = ((rs1 != '0) & busy_q[rs1] & ~hit1) |
            ((rs2 != '0) & busy_q[rs2] & ~hit2);
  end

  a_src_protocol: assert property (@(posedge clk) disable iff (!rst)
    !((mem_vld || alu_vld) && !src_ready))
    else $error("regfile_wb_ctrl: source valid while src_ready=0, result dropped");

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed table-driven bench for regfile_wb_ctrl plus queue-pressure and reset sequences.
module tb_regfile_wb_ctrl;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_vld = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        alu_vld = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        mem_vld = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_data = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic        src_ready, stall, we, fwd1_vld, fwd2_vld;
  logic [4:0]  rd;
  logic [31:0] wd, fwd1_data, fwd2_data;

  int tests = 0;
  int fails = 0;

  regfile_wb_ctrl #(.XLEN(32), .REG_AW(5), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .issue_vld(issue_vld), .issue_rd(issue_rd),
    .alu_vld(alu_vld), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_vld(mem_vld), .mem_rd(mem_rd), .mem_data(mem_data),
    .src_ready(src_ready), .rs1(rs1), .rs2(rs2), .stall(stall),
    .we(we), .rd(rd), .wd(wd),
    .fwd1_vld(fwd1_vld), .fwd2_vld(fwd2_vld),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;  logic [4:0] ird;
    logic        av;  logic [4:0] ard; logic [31:0] ad;
    logic        mv;  logic [4:0] mrd; logic [31:0] md;
    logic [4:0]  r1;  logic [4:0] r2;
    logic        ewe; logic [4:0] erd; logic [31:0] ewd;
    logic        est_nb; logic est_b; logic esr;
  } vec_t;

  vec_t vecs [12];
  logic [4:0]  exp_rdq [$];
  logic [31:0] exp_wdq [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    issue_vld = v.iv; issue_rd = v.ird;
    alu_vld = v.av; alu_rd = v.ard; alu_data = v.ad;
    mem_vld = v.mv; mem_rd = v.mrd; mem_data = v.md;
    rs1 = v.r1; rs2 = v.r2;
  endtask

  task automatic idle();
    issue_vld = 0; alu_vld = 0; mem_vld = 0;
    issue_rd = 0; alu_rd = 0; mem_rd = 0;
  endtask

  task automatic observe(input string tag);
    if (we) begin
      if (exp_rdq.size() == 0) begin
        chk({tag, " unexpected we"}, we, 0);
      end else begin
        chk({tag, " rd"}, rd, exp_rdq.pop_front());
        chk({tag, " wd"}, wd, exp_wdq.pop_front());
      end
    end
  endtask

  initial begin
    logic exp_f1, exp_f2;
    //           iv ird av ard ad            mv mrd md     r1 r2 we rd wd            snb sb sr
    vecs[0]  = '{1, 5,  0, 0,  0,            0, 0,  0,     0, 0, 0, 0, 0,            0,  0, 1};
    vecs[1]  = '{0, 0,  0, 0,  0,            0, 0,  0,     5, 0, 0, 0, 0,            1,  1, 1};
    vecs[2]  = '{0, 0,  1, 5,  32'hDEADBEEF, 0, 0,  0,     5, 0, 1, 5, 32'hDEADBEEF, 0,  0, 1};
    vecs[3]  = '{0, 0,  0, 0,  0,            0, 0,  0,     5, 0, 0, 0, 0,            0,  0, 1};
    vecs[4]  = '{0, 0,  1, 4,  32'h22,       1, 3,  32'h11, 0, 0, 1, 3, 32'h11,      0,  0, 1};
    vecs[5]  = '{0, 0,  0, 0,  0,            0, 0,  0,     0, 0, 1, 4, 32'h22,       0,  0, 1};
    vecs[6]  = '{0, 0,  0, 0,  0,            0, 0,  0,     0, 0, 0, 0, 0,            0,  0, 1};
    vecs[7]  = '{1, 0,  1, 0,  32'hFF,       0, 0,  0,     0, 0, 0, 0, 0,            0,  0, 1};
    vecs[8]  = '{0, 0,  0, 0,  0,            0, 0,  0,     0, 0, 0, 0, 0,            0,  0, 1};
    vecs[9]  = '{1, 7,  0, 0,  0,            0, 0,  0,     0, 0, 0, 0, 0,            0,  0, 1};
    vecs[10] = '{1, 7,  1, 7,  32'hA5,       0, 0,  0,     0, 7, 1, 7, 32'hA5,       1,  0, 1};
    vecs[11] = '{0, 0,  1, 7,  32'h5A,       0, 0,  0,     0, 7, 1, 7, 32'h5A,       0,  0, 1};

    // Reset state
    #2;
    chk("reset we", we, 0);
    chk("reset rd", rd, 0);
    chk("reset wd", wd, 0);
    chk("reset src_ready", src_ready, 1);
    chk("reset fwd1_vld", fwd1_vld, 0);
    chk("reset fwd2_vld", fwd2_vld, 0);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset stall", stall, 0);

    // Table: inputs held across one rising edge, outputs checked just after it
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i]);
      step();
      chk($sformatf("row%0d we", i), we, vecs[i].ewe);
      if (vecs[i].ewe) begin
        chk($sformatf("row%0d rd", i), rd, vecs[i].erd);
        chk($sformatf("row%0d wd", i), wd, vecs[i].ewd);
      end
      chk($sformatf("row%0d stall", i), stall, BYP ? vecs[i].est_b : vecs[i].est_nb);
      chk($sformatf("row%0d src_ready", i), src_ready, vecs[i].esr);
      exp_f1 = BYP && vecs[i].ewe && vecs[i].erd != 0 && vecs[i].erd == vecs[i].r1;
      exp_f2 = BYP && vecs[i].ewe && vecs[i].erd != 0 && vecs[i].erd == vecs[i].r2;
      chk($sformatf("row%0d fwd1_vld", i), fwd1_vld, exp_f1);
      chk($sformatf("row%0d fwd2_vld", i), fwd2_vld, exp_f2);
      if (exp_f1 || !BYP)
        chk($sformatf("row%0d fwd1_data", i), fwd1_data, BYP ? vecs[i].ewd : 32'h0);
      if (exp_f2 || !BYP)
        chk($sformatf("row%0d fwd2_data", i), fwd2_data, BYP ? vecs[i].ewd : 32'h0);
    end
    idle(); rs1 = 0; rs2 = 0;
    step();

    // Queue pressure: three back-to-back collisions fill DEPTH=4 to 3
    for (int k = 1; k <= 6; k++) begin
      exp_rdq.push_back(5'(k));
      exp_wdq.push_back(32'hA0 + 32'(k));
    end
    for (int c = 0; c < 3; c++) begin
      mem_vld = 1; mem_rd = 5'(2*c + 1); mem_data = 32'hA0 + 32'(2*c + 1);
      alu_vld = 1; alu_rd = 5'(2*c + 2); alu_data = 32'hA0 + 32'(2*c + 2);
      step();
      observe($sformatf("t4 fill%0d", c));
      chk($sformatf("t4 fill%0d src_ready", c), src_ready, (c < 2) ? 1'b1 : 1'b0);
    end
    idle();
    for (int d = 0; d < 8; d++) begin
      step();
      observe($sformatf("t4 drain%0d", d));
      if (d == 0) chk("t4 src_ready restored", src_ready, 1);
    end
    chk("t4 writes outstanding", exp_rdq.size(), 0);

    // Reset mid-operation with two writes queued and a busy register
    issue_vld = 1; issue_rd = 9;
    mem_vld = 1; mem_rd = 1; mem_data = 32'h1;
    alu_vld = 1; alu_rd = 2; alu_data = 32'h2;
    step();
    issue_vld = 0; issue_rd = 0;
    mem_rd = 3; mem_data = 32'h3;
    alu_rd = 4; alu_data = 32'h4;
    rs1 = 9;
    step();
    chk("t5 pre-reset we", we, 1);
    chk("t5 pre-reset stall", stall, 1);
    idle();
    #2;
    rst = 1'b0;
    #1;
    chk("t5 reset we", we, 0);
    chk("t5 reset rd", rd, 0);
    chk("t5 reset wd", wd, 0);
    chk("t5 reset stall", stall, 0);
    chk("t5 reset src_ready", src_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 6; n++) begin
      step();
      chk($sformatf("t5 post-release%0d we", n), we, 0);
    end
    chk("t5 post-release stall", stall, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
